// File: rtl/fsa_result_pkg.sv
// fsa_result_pkg: constants, record layout and snapshot type for the frame-analysis result transmitter.
// FSA_RESULT_TX_INNER_EN selects the 10-word record (inner headers included) over the 8-word record.
package fsa_result_pkg;

    localparam logic [7:0] RES_MAGIC = 8'hA5;

    localparam int REC_WORDS_FULL     = 10;
    localparam int REC_WORDS_NO_INNER = 8;

`ifdef FSA_RESULT_TX_INNER_EN
    localparam bit INNER_EN = 1'b1;
`else
    localparam bit INNER_EN = 1'b0;
`endif

    localparam int         REC_WORDS = INNER_EN ? REC_WORDS_FULL : REC_WORDS_NO_INNER;
    localparam logic [3:0] LAST_IDX  = 4'(REC_WORDS - 1);

    localparam int FLAG_LFT_VALID  = 0;
    localparam int FLAG_LFT_OUTER  = 1;
    localparam int FLAG_LFT_INNER  = 2;
    localparam int FLAG_LFT_CORNER = 3;
    localparam int FLAG_RT_VALID   = 4;
    localparam int FLAG_RT_OUTER   = 5;
    localparam int FLAG_RT_INNER   = 6;
    localparam int FLAG_RT_CORNER  = 7;

    // Logical word identifiers of the full record
    localparam logic [3:0] W_HEAD      = 4'd0;
    localparam logic [3:0] W_EDGE      = 4'd1;
    localparam logic [3:0] W_LFT_OUTER = 4'd2;
    localparam logic [3:0] W_LFT_INNER = 4'd3;
    localparam logic [3:0] W_LFT_TOP   = 4'd4;
    localparam logic [3:0] W_LFT_BOT   = 4'd5;
    localparam logic [3:0] W_RT_OUTER  = 4'd6;
    localparam logic [3:0] W_RT_INNER  = 4'd7;
    localparam logic [3:0] W_RT_TOP    = 4'd8;
    localparam logic [3:0] W_RT_BOT    = 4'd9;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } res_point_t;

    typedef struct packed {
        logic [7:0]  seq;
        logic [7:0]  flags;
        logic [15:0] lft_edge;
        logic [15:0] rt_edge;
        res_point_t  lft_hdr_outer;
        res_point_t  lft_hdr_inner;
        res_point_t  lft_top;
        res_point_t  lft_bot;
        res_point_t  rt_hdr_outer;
        res_point_t  rt_hdr_inner;
        res_point_t  rt_top;
        res_point_t  rt_bot;
    } res_snapshot_t;

    // Maps the transmitted word index onto the logical word, skipping inner headers when they are absent
    function automatic logic [3:0] word_layout(input logic [3:0] idx);
        logic [3:0] w;
        w = idx;
`ifndef FSA_RESULT_TX_INNER_EN
        case (idx)
            4'd3:    w = W_LFT_TOP;
            4'd4:    w = W_LFT_BOT;
            4'd5:    w = W_RT_OUTER;
            4'd6:    w = W_RT_TOP;
            4'd7:    w = W_RT_BOT;
            default: w = idx;
        endcase
`endif
        return w;
    endfunction

endpackage

// File: rtl/fsa_result_tx_if.sv
// fsa_result_tx_if: 32-bit AXI4-Stream result channel; tuser marks word 0, tlast the final word.
interface fsa_result_tx_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/fsa_result_pack.sv
// fsa_result_pack: combinational selection of one 32-bit record word from a result snapshot.
// Word order follows FSA_RESULT_TX_INNER_EN through word_layout().
module fsa_result_pack
    import fsa_result_pkg::*;
(
    input  res_snapshot_t snap,
    input  logic [3:0]    idx,
    output logic [31:0]   word
);

    always_comb begin
        word = '0;
        case (word_layout(idx))
            W_HEAD:      word = {RES_MAGIC, snap.seq, 8'h00, snap.flags};
            W_EDGE:      word = {snap.lft_edge, snap.rt_edge};
            W_LFT_OUTER: word = snap.lft_hdr_outer;
            W_LFT_INNER: word = snap.lft_hdr_inner;
            W_LFT_TOP:   word = snap.lft_top;
            W_LFT_BOT:   word = snap.lft_bot;
            W_RT_OUTER:  word = snap.rt_hdr_outer;
            W_RT_INNER:  word = snap.rt_hdr_inner;
            W_RT_TOP:    word = snap.rt_top;
            W_RT_BOT:    word = snap.rt_bot;
            default:     word = '0;
        endcase
    end

endmodule

// File: rtl/fsa_result_tx.sv
// fsa_result_tx: snapshots per-frame analysis results on ana_done and streams them as an AXI4-Stream record.
// FSA_RESULT_TX_INNER_EN adds the inner header words (10-word record instead of 8).
module fsa_result_tx
    import fsa_result_pkg::*;
#(
    parameter int C_IMG_WW = 12,
    parameter int C_IMG_HW = 12
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic                tx_en,
    input  logic                ana_done,
    input  logic                res_lft_valid,
    input  logic                res_rt_valid,
    input  logic                res_lft_header_outer_valid,
    input  logic                res_lft_header_inner_valid,
    input  logic                res_rt_header_outer_valid,
    input  logic                res_rt_header_inner_valid,
    input  logic                res_lft_corner_valid,
    input  logic                res_rt_corner_valid,
    input  logic [C_IMG_WW-1:0] res_lft_edge,
    input  logic [C_IMG_WW-1:0] res_rt_edge,
    input  logic [C_IMG_WW-1:0] res_lft_header_outer_x,
    input  logic [C_IMG_WW-1:0] res_lft_header_outer_y,
    input  logic [C_IMG_WW-1:0] res_lft_header_inner_x,
    input  logic [C_IMG_WW-1:0] res_lft_header_inner_y,
    input  logic [C_IMG_WW-1:0] res_rt_header_outer_x,
    input  logic [C_IMG_WW-1:0] res_rt_header_outer_y,
    input  logic [C_IMG_WW-1:0] res_rt_header_inner_x,
    input  logic [C_IMG_WW-1:0] res_rt_header_inner_y,
    input  logic [C_IMG_WW-1:0] res_lft_corner_top_x,
    input  logic [C_IMG_HW-1:0] res_lft_corner_top_y,
    input  logic [C_IMG_WW-1:0] res_lft_corner_bot_x,
    input  logic [C_IMG_HW-1:0] res_lft_corner_bot_y,
    input  logic [C_IMG_WW-1:0] res_rt_corner_top_x,
    input  logic [C_IMG_HW-1:0] res_rt_corner_top_y,
    input  logic [C_IMG_WW-1:0] res_rt_corner_bot_x,
    input  logic [C_IMG_HW-1:0] res_rt_corner_bot_y,
    fsa_result_tx_if.master     m_axis,
    output logic [7:0]          seq,
    output logic [15:0]         drop_cnt,
    output logic                busy
);

    tx_state_t     state_q, state_nxt;
    logic [3:0]    idx_q, idx_nxt;
    res_snapshot_t snap_q, snap_nxt, cap_snap;
    logic [31:0]   word_nxt;
    logic [31:0]   tdata_q;
    logic          tuser_q, tlast_q;
    logic          capture, handshake, last_hs, load, drop;

    assign capture   = ana_done && tx_en;
    assign handshake = (state_q == ST_SEND) && m_axis.tready;
    assign last_hs   = handshake && (idx_q == LAST_IDX);

    // Snapshot image of the current inputs; the record carries the sequence number before it advances
    always_comb begin
        cap_snap                         = '0;
        cap_snap.seq                     = seq;
        cap_snap.flags[FLAG_LFT_VALID]   = res_lft_valid;
        cap_snap.flags[FLAG_LFT_OUTER]   = res_lft_header_outer_valid;
        cap_snap.flags[FLAG_LFT_CORNER]  = res_lft_corner_valid;
        cap_snap.flags[FLAG_RT_VALID]    = res_rt_valid;
        cap_snap.flags[FLAG_RT_OUTER]    = res_rt_header_outer_valid;
        cap_snap.flags[FLAG_RT_CORNER]   = res_rt_corner_valid;
        cap_snap.lft_edge                = 16'(res_lft_edge);
        cap_snap.rt_edge                 = 16'(res_rt_edge);
        cap_snap.lft_hdr_outer           = {16'(res_lft_header_outer_y), 16'(res_lft_header_outer_x)};
        cap_snap.lft_top                 = {16'(res_lft_corner_top_y), 16'(res_lft_corner_top_x)};
        cap_snap.lft_bot                 = {16'(res_lft_corner_bot_y), 16'(res_lft_corner_bot_x)};
        cap_snap.rt_hdr_outer            = {16'(res_rt_header_outer_y), 16'(res_rt_header_outer_x)};
        cap_snap.rt_top                  = {16'(res_rt_corner_top_y), 16'(res_rt_corner_top_x)};
        cap_snap.rt_bot                  = {16'(res_rt_corner_bot_y), 16'(res_rt_corner_bot_x)};
`ifdef FSA_RESULT_TX_INNER_EN
        cap_snap.flags[FLAG_LFT_INNER]   = res_lft_header_inner_valid;
        cap_snap.flags[FLAG_RT_INNER]    = res_rt_header_inner_valid;
        cap_snap.lft_hdr_inner           = {16'(res_lft_header_inner_y), 16'(res_lft_header_inner_x)};
        cap_snap.rt_hdr_inner            = {16'(res_rt_header_inner_y), 16'(res_rt_header_inner_x)};
`endif
    end

`ifndef FSA_RESULT_TX_INNER_EN
    logic unused_inner;
    assign unused_inner = ^{res_lft_header_inner_valid, res_rt_header_inner_valid,
                            res_lft_header_inner_x, res_lft_header_inner_y,
                            res_rt_header_inner_x, res_rt_header_inner_y};
`endif

    // A capture landing on the last-word handshake chains straight into the next record instead of dropping
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        load      = 1'b0;
        drop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    load      = 1'b1;
                    idx_nxt   = 4'd0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_hs) begin
                    idx_nxt = 4'd0;
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (handshake) begin
                    idx_nxt = idx_q + 4'd1;
                end
                if (capture && !last_hs) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = 4'd0;
            end
        endcase
    end

    assign snap_nxt = load ? cap_snap : snap_q;

    fsa_result_pack u_pack (
        .snap (snap_nxt),
        .idx  (idx_nxt),
        .word (word_nxt)
    );

    // Output word is registered from the next-cycle snapshot and index, so a stalled beat stays stable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            snap_q   <= '0;
            seq      <= 8'd0;
            drop_cnt <= 16'd0;
            tdata_q  <= 32'd0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            snap_q  <= snap_nxt;
            if (capture) begin
                seq <= seq + 8'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (state_nxt == ST_SEND) begin
                tdata_q <= word_nxt;
                tuser_q <= (idx_nxt == W_HEAD);
                tlast_q <= (idx_nxt == LAST_IDX);
            end else begin
                tuser_q <= 1'b0;
                tlast_q <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = (state_q == ST_SEND);
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q == ST_SEND);

endmodule

// File: tb/tb_fsa_result_tx.sv
// tb_fsa_result_tx: self-checking bench for fsa_result_tx with a queue-of-records reference model.
// Builds with or without FSA_RESULT_TX_INNER_EN, matching the design.
module tb_fsa_result_tx;

    localparam int WW = 12;
    localparam int HW = 12;
`ifdef FSA_RESULT_TX_INNER_EN
    localparam int NWORDS = 10;
    localparam bit INNER  = 1'b1;
`else
    localparam int NWORDS = 8;
    localparam bit INNER  = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0]    vld;
        logic [WW-1:0] le;
        logic [WW-1:0] re;
        logic [31:0]   w0;
        logic [31:0]   w1;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          tx_en;
    logic          ana_done;
    logic [7:0]    vld;
    logic [WW-1:0] lft_edge;
    logic [WW-1:0] rt_edge;
    logic [WW-1:0] pt_x [8];
    logic [HW-1:0] pt_y [8];
    logic [7:0]    seq;
    logic [15:0]   drop_cnt;
    logic          busy;

    beat_t       exp_q[$];
    logic [7:0]  m_seq;
    logic [15:0] m_drop;
    int          tests = 0;
    int          fails = 0;

    fsa_result_tx_if axis ();

    fsa_result_tx #(.C_IMG_WW(WW), .C_IMG_HW(HW)) dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .tx_en                      (tx_en),
        .ana_done                   (ana_done),
        .res_lft_valid              (vld[0]),
        .res_rt_valid               (vld[4]),
        .res_lft_header_outer_valid (vld[1]),
        .res_lft_header_inner_valid (vld[2]),
        .res_rt_header_outer_valid  (vld[5]),
        .res_rt_header_inner_valid  (vld[6]),
        .res_lft_corner_valid       (vld[3]),
        .res_rt_corner_valid        (vld[7]),
        .res_lft_edge               (lft_edge),
        .res_rt_edge                (rt_edge),
        .res_lft_header_outer_x     (pt_x[0]),
        .res_lft_header_outer_y     (pt_y[0]),
        .res_lft_header_inner_x     (pt_x[1]),
        .res_lft_header_inner_y     (pt_y[1]),
        .res_rt_header_outer_x      (pt_x[4]),
        .res_rt_header_outer_y      (pt_y[4]),
        .res_rt_header_inner_x      (pt_x[5]),
        .res_rt_header_inner_y      (pt_y[5]),
        .res_lft_corner_top_x       (pt_x[2]),
        .res_lft_corner_top_y       (pt_y[2]),
        .res_lft_corner_bot_x       (pt_x[3]),
        .res_lft_corner_bot_y       (pt_y[3]),
        .res_rt_corner_top_x        (pt_x[6]),
        .res_rt_corner_top_y        (pt_y[6]),
        .res_rt_corner_bot_x        (pt_x[7]),
        .res_rt_corner_bot_y        (pt_y[7]),
        .m_axis                     (axis),
        .seq                        (seq),
        .drop_cnt                   (drop_cnt),
        .busy                       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected record built straight from the word list: header, edges, then the eight points in order
    function automatic void pushRecord(input logic [7:0] s);
        logic [31:0] w [10];
        logic [7:0]  f;
        beat_t       b;
        int          n;
        f = vld;
`ifndef FSA_RESULT_TX_INNER_EN
        f[2] = 1'b0;
        f[6] = 1'b0;
`endif
        w[0] = {8'hA5, s, 8'h00, f};
        w[1] = {16'(lft_edge), 16'(rt_edge)};
        for (int p = 0; p < 8; p++) begin
            w[p+2] = {16'(pt_y[p]), 16'(pt_x[p])};
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
`ifndef FSA_RESULT_TX_INNER_EN
            if (i == 3 || i == 7) continue;
`endif
            b.data = w[i];
            b.user = (n == 0);
            b.last = (n == NWORDS - 1);
            exp_q.push_back(b);
            n++;
        end
    endfunction

    task automatic stepModel();
        logic exp_v;
        exp_v = (exp_q.size() != 0);
        checkOutput("tvalid", 32'(axis.tvalid), 32'(exp_v));
        checkOutput("busy", 32'(busy), 32'(exp_v));
        checkOutput("seq", 32'(seq), 32'(m_seq));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (exp_v) begin
            checkOutput("tdata", axis.tdata, exp_q[0].data);
            checkOutput("tuser", 32'(axis.tuser), 32'(exp_q[0].user));
            checkOutput("tlast", 32'(axis.tlast), 32'(exp_q[0].last));
            if (axis.tready) void'(exp_q.pop_front());
        end
        // A new record is accepted only if nothing is left in flight after this cycle's beat
        if (ana_done && tx_en) begin
            if (exp_q.size() == 0) pushRecord(m_seq);
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_seq = m_seq + 8'd1;
        end
    endtask

    task automatic applyStimulus(input logic done_i, input logic ready_i);
        ana_done    = done_i;
        axis.tready = ready_i;
        #1;
        stepModel();
        @(negedge clk);
    endtask

    task automatic randomizeData();
        vld      = 8'($urandom);
        lft_edge = WW'($urandom);
        rt_edge  = WW'($urandom);
        for (int p = 0; p < 8; p++) begin
            pt_x[p] = WW'($urandom);
            pt_y[p] = HW'($urandom);
        end
    endtask

    task automatic doReset();
        resetn = 1'b0;
        exp_q.delete();
        m_seq  = 8'd0;
        m_drop = 16'd0;
        #1;
        checkOutput("rst_tvalid", 32'(axis.tvalid), 32'd0);
        checkOutput("rst_tdata", axis.tdata, 32'd0);
        checkOutput("rst_tuser", 32'(axis.tuser), 32'd0);
        checkOutput("rst_tlast", 32'(axis.tlast), 32'd0);
        checkOutput("rst_seq", 32'(seq), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            applyStimulus(1'b0, 1'b1);
            c++;
        end
        checkOutput({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t  vt [4];
        beat_t got [16];
        int    n;
        int    first_c;
        int    last_c;
        bit    done;
        bit    found;

        vt[0] = '{8'hFF, 12'd100,  12'd900,  (INNER ? 32'hA50000FF : 32'hA50000BB), 32'h00640384};
        vt[1] = '{8'h00, 12'd0,    12'd0,    32'hA5010000,                              32'h00000000};
        vt[2] = '{8'h44, 12'd4095, 12'd1,    (INNER ? 32'hA5020044 : 32'hA5020000), 32'h0FFF0001};
        vt[3] = '{8'h11, 12'd2048, 12'd3000, 32'hA5030011,                              32'h08000BB8};

        tx_en       = 1'b0;
        ana_done    = 1'b0;
        axis.tready = 1'b0;
        vld         = 8'h00;
        lft_edge    = '0;
        rt_edge     = '0;
        for (int p = 0; p < 8; p++) begin
            pt_x[p] = '0;
            pt_y[p] = '0;
        end
        doReset();

        // Table of single frames with tready held high; sequence numbers run 0..3 from reset
        for (int i = 0; i < 4; i++) begin
            randomizeData();
            vld      = vt[i].vld;
            lft_edge = vt[i].le;
            rt_edge  = vt[i].re;
            tx_en    = 1'b1;
            applyStimulus(1'b1, 1'b1);
            for (int k = 0; k < 16; k++) begin
                got[k].data = '0;
                got[k].user = 1'b0;
                got[k].last = 1'b0;
            end
            n = 0; first_c = -1; last_c = -1; done = 1'b0;
            for (int c = 0; c < 3 * NWORDS && !done; c++) begin
                ana_done    = 1'b0;
                axis.tready = 1'b1;
                #1;
                if (axis.tvalid) begin
                    if (first_c < 0) first_c = c;
                    if (n < 16) begin
                        got[n].data = axis.tdata;
                        got[n].user = axis.tuser;
                        got[n].last = axis.tlast;
                    end
                    n++;
                    if (axis.tlast) begin
                        done   = 1'b1;
                        last_c = c;
                    end
                end
                stepModel();
                @(negedge clk);
            end
            checkOutput("vec_done", 32'(done), 32'd1);
            checkOutput("vec_beats", 32'(n), 32'(NWORDS));
            checkOutput("vec_w0", got[0].data, vt[i].w0);
            checkOutput("vec_w1", got[1].data, vt[i].w1);
            checkOutput("vec_tuser_w0", 32'(got[0].user), 32'd1);
            checkOutput("vec_tuser_w1", 32'(got[1].user), 32'd0);
            checkOutput("vec_tlast_final", 32'(got[NWORDS-1].last), 32'd1);
            checkOutput("vec_tlast_early", 32'(got[NWORDS-2].last), 32'd0);
            checkOutput("vec_first_cycle", 32'(first_c), 32'd0);
            checkOutput("vec_last_cycle", 32'(last_c), 32'(NWORDS - 1));
        end

        // Backpressure: tready alternates 0/1, so the record takes twice its word count
        randomizeData();
        applyStimulus(1'b1, 1'b0);
        last_c = -1;
        for (int c = 0; c < 4 * NWORDS && last_c < 0; c++) begin
            ana_done    = 1'b0;
            axis.tready = (c % 2) == 1;
            #1;
            if (axis.tvalid && axis.tready && axis.tlast) last_c = c;
            stepModel();
            @(negedge clk);
        end
        checkOutput("bp_cycles", 32'(last_c + 1), 32'(2 * NWORDS));

        // Overlap: a second capture at word 4 is dropped and leaves the first snapshot in flight
        doReset();
        randomizeData();
        applyStimulus(1'b1, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1);
        randomizeData();
        applyStimulus(1'b1, 1'b1);
        checkOutput("ovl_drop", 32'(drop_cnt), 32'd1);
        checkOutput("ovl_seq", 32'(seq), 32'd2);
        checkOutput("ovl_busy", 32'(busy), 32'd1);
        drain("ovl");

        // Back-to-back: capture on the last-word handshake starts the next record with no gap
        doReset();
        randomizeData();
        applyStimulus(1'b1, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 3 * NWORDS && !found; c++) begin
            if (axis.tlast) begin
                randomizeData();
                applyStimulus(1'b1, 1'b1);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b1);
            end
        end
        checkOutput("b2b_found_last", 32'(found), 32'd1);
        checkOutput("b2b_tvalid", 32'(axis.tvalid), 32'd1);
        checkOutput("b2b_tuser", 32'(axis.tuser), 32'd1);
        checkOutput("b2b_seq_field", 32'(axis.tdata[23:16]), 32'd1);
        checkOutput("b2b_drop", 32'(drop_cnt), 32'd0);
        drain("b2b");

        // tx_en low: pulses are ignored entirely
        tx_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("txen_tvalid", 32'(axis.tvalid), 32'd0);
        checkOutput("txen_seq", 32'(seq), 32'd2);
        checkOutput("txen_drop", 32'(drop_cnt), 32'd0);

        // Asynchronous reset mid-record, between clock edges
        tx_en = 1'b1;
        randomizeData();
        applyStimulus(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_tvalid_before", 32'(axis.tvalid), 32'd1);
        #2;
        doReset();

        // Randomized traffic against the record model
        for (int c = 0; c < 3000; c++) begin
            tx_en = ($urandom_range(0, 9) != 0);
            randomizeData();
            applyStimulus(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) != 0));
        end
        tx_en = 1'b1;
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
